// File: rtl/pbvi_pkg.sv
// Shared constants, FSM encodings and write-payload type for the PBVI alpha backup stage.
package pbvi_pkg;

    localparam int unsigned NUM_S  = 2;        // states s0,s1
    localparam int unsigned NUM_A  = 3;        // actions
    localparam int unsigned NUM_B  = 16;       // belief points
    localparam int unsigned AW     = 6;        // alpha-store address width
    localparam int unsigned BW     = 4;        // belief index width
    localparam int unsigned AIW    = 2;        // action index width
    localparam int unsigned DW     = 16;       // alpha / reward / discount width
    localparam int unsigned FRAC_W = 16;       // Q0.16 fraction width of disc
    localparam int unsigned PW     = 2 * DW;   // full product width

    localparam logic [AIW-1:0] A_LAST = AIW'(NUM_A - 1);
    localparam logic [BW-1:0]  B_LAST = BW'(NUM_B - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CALC  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;
    } alpha_wr_t;

    // Base address of an action's block in the alpha store.
    function automatic logic [AW-1:0] action_offset(input logic [AIW-1:0] a);
        return AW'(a) * AW'(NUM_B);
    endfunction

    function automatic logic [AW-1:0] alpha_addr(input logic [AIW-1:0] a,
                                                 input logic [BW-1:0]  b);
        return action_offset(a) + AW'(b);
    endfunction

endpackage

// File: rtl/pbvi_alpha_backup_if.sv
// Memory-side bus of the alpha backup stage.
//   prev_rd_en/prev_rd_addr -> best-alpha store, prev_rd_s0/s1 returned one cycle later
//   wr_valid/wr_ready handshake with wr_addr/wr_s0/wr_s1 payload -> alpha store
// master: the backup stage; slave: the stores.
interface pbvi_alpha_backup_if;
    import pbvi_pkg::*;

    logic          prev_rd_en;
    logic [BW-1:0] prev_rd_addr;
    logic [DW-1:0] prev_rd_s0;
    logic [DW-1:0] prev_rd_s1;

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_s0;
    logic [DW-1:0] wr_s1;

    modport master (
        output prev_rd_en, prev_rd_addr,
        input  prev_rd_s0, prev_rd_s1,
        output wr_valid, wr_addr, wr_s0, wr_s1,
        input  wr_ready
    );

    modport slave (
        input  prev_rd_en, prev_rd_addr,
        output prev_rd_s0, prev_rd_s1,
        input  wr_valid, wr_addr, wr_s0, wr_s1,
        output wr_ready
    );

endinterface

// File: rtl/pbvi_backup_dp.sv
// One alpha component: out = sat16(reward + ((disc * prev) >> 16)).
//   disc    in  Q0.16 discount
//   prev    in  previous best alpha component
//   reward  in  R[a][s]
//   alpha_c out combinational result
module pbvi_backup_dp
    import pbvi_pkg::*;
(
    input  logic [DW-1:0] disc,
    input  logic [DW-1:0] prev,
    input  logic [DW-1:0] reward,
    output logic [DW-1:0] alpha_c
);

    logic [PW-1:0] prod_c;
    logic [DW-1:0] term_c;
    logic [DW:0]   sum_c;

    // Truncating Q0.16 scale, 17-bit add, saturate on carry.
    always_comb begin
        prod_c  = PW'(disc) * PW'(prev);
        term_c  = DW'(prod_c >> FRAC_W);
        sum_c   = {1'b0, reward} + {1'b0, term_c};
        alpha_c = sum_c[DW] ? {DW{1'b1}} : sum_c[DW-1:0];
    end

endmodule

// File: rtl/pbvi_alpha_backup.sv
// PBVI value-backup sweep: for every belief b (outer) and action a (inner) writes
// gamma[a][b][s] = R[a][s] + disc*prev_best[b][s] to the alpha store at a*NUM_B+b.
//   clk, rst          clock, async active-high reset
//   start, disc       sweep trigger and Q0.16 discount (latched on accepted start)
//   cfg_we/a/s/data   reward table write port, honoured only while idle
//   bus (master)      best-alpha read port and alpha-store write handshake
//   busy, done        sweep in progress, one-cycle completion pulse
module pbvi_alpha_backup
    import pbvi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DW-1:0]        disc,
    input  logic                 cfg_we,
    input  logic [AIW-1:0]       cfg_a,
    input  logic                 cfg_s,
    input  logic [DW-1:0]        cfg_data,
    pbvi_alpha_backup_if.master  bus,
    output logic                 busy,
    output logic                 done
);

    logic [2:0]     state_q, state_d;
    logic [AIW-1:0] a_q, a_d;
    logic [BW-1:0]  b_q, b_d;
    logic [DW-1:0]  disc_q, disc_d;
    logic [DW-1:0]  prev_s0_q, prev_s0_d;
    logic [DW-1:0]  prev_s1_q, prev_s1_d;
    logic [DW-1:0]  reward_q [NUM_A][NUM_S];
    logic [DW-1:0]  reward_d [NUM_A][NUM_S];
    logic           rd_en_q, rd_en_d;
    logic [BW-1:0]  rd_addr_q, rd_addr_d;
    logic           wr_valid_q, wr_valid_d;
    alpha_wr_t      wr_q, wr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [DW-1:0]  alpha_s0_c;
    logic [DW-1:0]  alpha_s1_c;

    pbvi_backup_dp u_dp_s0 (
        .disc    (disc_q),
        .prev    (prev_s0_q),
        .reward  (reward_q[a_q][0]),
        .alpha_c (alpha_s0_c)
    );

    pbvi_backup_dp u_dp_s1 (
        .disc    (disc_q),
        .prev    (prev_s1_q),
        .reward  (reward_q[a_q][1]),
        .alpha_c (alpha_s1_c)
    );

    // Next-state and next-output logic; outputs are registered from the *_d values.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        disc_d     = disc_q;
        prev_s0_d  = prev_s0_q;
        prev_s1_d  = prev_s1_q;
        reward_d   = reward_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A same-cycle reward write lands before the first CALC reads it.
                if (cfg_we && (cfg_a <= A_LAST)) begin
                    reward_d[cfg_a][cfg_s] = cfg_data;
                end
                if (start) begin
                    disc_d    = disc;
                    a_d       = '0;
                    b_d       = '0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    state_d   = ST_READ;
                end
            end

            ST_READ: begin
                state_d = ST_WAIT;
            end

            // Read data arrives this cycle; it serves every action of this belief.
            ST_WAIT: begin
                prev_s0_d = bus.prev_rd_s0;
                prev_s1_d = bus.prev_rd_s1;
                state_d   = ST_CALC;
            end

            ST_CALC: begin
                wr_d.addr  = alpha_addr(a_q, b_q);
                wr_d.s0    = alpha_s0_c;
                wr_d.s1    = alpha_s1_c;
                wr_valid_d = 1'b1;
                state_d    = ST_WRITE;
            end

            // Payload is held until the store takes it.
            ST_WRITE: begin
                if (bus.wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (a_q < A_LAST) begin
                        a_d     = a_q + AIW'(1);
                        state_d = ST_CALC;
                    end else begin
                        a_d = '0;
                        if (b_q < B_LAST) begin
                            b_d       = b_q + BW'(1);
                            rd_en_d   = 1'b1;
                            rd_addr_d = b_q + BW'(1);
                            state_d   = ST_READ;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            disc_q     <= '0;
            prev_s0_q  <= '0;
            prev_s1_q  <= '0;
            for (int i = 0; i < int'(NUM_A); i++) begin
                for (int j = 0; j < int'(NUM_S); j++) begin
                    reward_q[i][j] <= '0;
                end
            end
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            disc_q     <= disc_d;
            prev_s0_q  <= prev_s0_d;
            prev_s1_q  <= prev_s1_d;
            reward_q   <= reward_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.prev_rd_en   = rd_en_q;
    assign bus.prev_rd_addr = rd_addr_q;
    assign bus.wr_valid     = wr_valid_q;
    assign bus.wr_addr      = wr_q.addr;
    assign bus.wr_s0        = wr_q.s0;
    assign bus.wr_s1        = wr_q.s1;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
